// File: rtl/mod_frame_if.sv
`timescale 1ns/1ps
// Frame controller bus: frame request/abort, payload valid/ready stream and
// the paced serial output towards the 16QAM serial-to-parallel stage.
interface mod_frame_if;
    logic       start;
    logic       abort;
    logic [7:0] frame_len;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       signal;
    logic       bit_en;
    logic       sym_strobe;
    logic       busy;
    logic       done;
    logic       underrun;

    // Requester side: issues frames and supplies payload bytes
    modport master (
        output start, abort, frame_len, in_data, in_valid,
        input  in_ready, signal, bit_en, sym_strobe, busy, done, underrun
    );

    // Controller side
    modport slave (
        input  start, abort, frame_len, in_data, in_valid,
        output in_ready, signal, bit_en, sym_strobe, busy, done, underrun
    );
endinterface

// File: rtl/mod_frame_ctrl.sv
`timescale 1ns/1ps
// Frame scheduler for the 16QAM modulator serial input.
// Emits preamble symbols, a 16-bit sync word, frame_len payload bytes and
// trailing guard symbols, one bit every CLK_DIV clocks, MSB first.
// Every section is a whole number of 4-bit symbols, so the bit position
// inside the current section also gives the symbol phase for sym_strobe.
module mod_frame_ctrl #(
    parameter int          CLK_DIV       = 8,
    parameter int          PREAMBLE_SYMS = 8,
    parameter logic [3:0]  PREAMBLE_WORD = 4'b1001,
    parameter logic [15:0] SYNC_WORD     = 16'hF3A0,
    parameter int          GUARD_SYMS    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mod_frame_if.slave  fb
);

    localparam int DIV_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int PRE_BITS   = 4 * PREAMBLE_SYMS;
    localparam int GUARD_BITS = 4 * GUARD_SYMS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        SYNC  = 3'd2,
        PAY   = 3'd3,
        GUARD = 3'd4
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [15:0]        bit_cnt;     // bit position inside the current section (per byte in PAY)
    logic [7:0]         len_q;
    logic [7:0]         bytes_acc;
    logic [7:0]         bytes_sent;
    logic [7:0]         buf_q;
    logic               buf_full;
    logic [7:0]         shift_q;
    logic               sig_q;
    logic               done_q;
    logic               underrun_q;

    logic               bit_en_c;
    logic               in_ready_c;
    logic               accept_c;
    logic               load_c;
    logic [7:0]         load_byte_c;
    logic [15:0]        nxt_cnt_c;

    // Bit pacing, payload handshake and shifter-load decode
    always_comb begin
        bit_en_c    = (state != IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
        in_ready_c  = ((state == SYNC) || (state == PAY)) && !buf_full && (bytes_acc < len_q);
        accept_c    = fb.in_valid && in_ready_c;
        load_c      = bit_en_c &&
                      (((state == SYNC) && (bit_cnt == 16'd15)) ||
                       ((state == PAY) && (bit_cnt[2:0] == 3'd7) && (bytes_sent != len_q)));
        // An empty holding buffer at load time sends a zero byte; a byte
        // arriving on the same clock is not bypassed into the shifter.
        load_byte_c = buf_full ? buf_q : 8'h00;
        nxt_cnt_c   = bit_cnt + 16'd1;
    end

    // Frame sequencer: divider, section counters, payload buffer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            len_q      <= '0;
            bytes_acc  <= '0;
            bytes_sent <= '0;
            buf_q      <= '0;
            buf_full   <= 1'b0;
            shift_q    <= '0;
            sig_q      <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (fb.abort) begin
                // Abort drops the frame and any held byte; underrun stays sticky
                state    <= IDLE;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                sig_q    <= 1'b0;
                buf_full <= 1'b0;
            end else begin
                if (state == IDLE) begin
                    div_cnt <= '0;
                end else if (bit_en_c) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (fb.start && (fb.frame_len != 8'd0)) begin
                            state      <= PRE;
                            len_q      <= fb.frame_len;
                            bit_cnt    <= '0;
                            sig_q      <= PREAMBLE_WORD[3];
                            underrun_q <= 1'b0;
                            bytes_acc  <= '0;
                            bytes_sent <= '0;
                            buf_full   <= 1'b0;
                        end
                    end
                    PRE: begin
                        if (bit_en_c) begin
                            if (bit_cnt == 16'(PRE_BITS - 1)) begin
                                state   <= SYNC;
                                bit_cnt <= '0;
                                sig_q   <= SYNC_WORD[15];
                            end else begin
                                bit_cnt <= nxt_cnt_c;
                                sig_q   <= PREAMBLE_WORD[~nxt_cnt_c[1:0]];
                            end
                        end
                    end
                    SYNC: begin
                        if (bit_en_c) begin
                            if (bit_cnt == 16'd15) begin
                                state <= PAY;
                            end else begin
                                bit_cnt <= nxt_cnt_c;
                                sig_q   <= SYNC_WORD[~nxt_cnt_c[3:0]];
                            end
                        end
                    end
                    PAY: begin
                        if (bit_en_c) begin
                            if (bit_cnt[2:0] == 3'd7) begin
                                if (bytes_sent == len_q) begin
                                    state   <= GUARD;
                                    bit_cnt <= '0;
                                    sig_q   <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= nxt_cnt_c;
                                sig_q   <= shift_q[6];
                                shift_q <= {shift_q[6:0], 1'b0};
                            end
                        end
                    end
                    GUARD: begin
                        sig_q <= 1'b0;
                        if (bit_en_c) begin
                            if (bit_cnt == 16'(GUARD_BITS - 1)) begin
                                state   <= IDLE;
                                bit_cnt <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                bit_cnt <= nxt_cnt_c;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase

                if (load_c) begin
                    shift_q    <= load_byte_c;
                    sig_q      <= load_byte_c[7];
                    bit_cnt    <= '0;
                    bytes_sent <= bytes_sent + 8'd1;
                    buf_full   <= 1'b0;
                    if (!buf_full) begin
                        underrun_q <= 1'b1;
                    end
                end

                if (accept_c) begin
                    buf_q     <= fb.in_data;
                    buf_full  <= 1'b1;
                    bytes_acc <= bytes_acc + 8'd1;
                end
            end
        end
    end

    assign fb.in_ready   = in_ready_c;
    assign fb.signal     = sig_q;
    assign fb.bit_en     = bit_en_c;
    assign fb.sym_strobe = bit_en_c && (bit_cnt[1:0] == 2'b11);
    assign fb.busy       = (state != IDLE);
    assign fb.done       = done_q;
    assign fb.underrun   = underrun_q;

endmodule

// File: tb/tb_mod_frame_ctrl.sv
`timescale 1ns/1ps
// Bench for mod_frame_ctrl: a timeline model derives every output from the
// clock offset since the accepted start; literal checks pin frame contents.
module tb_mod_frame_ctrl;

    localparam int D = 8;
    localparam int P = 8;
    localparam int G = 2;
    localparam int PB = 4 * P + 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    mod_frame_if bus();

    mod_frame_ctrl #(
        .CLK_DIV(D), .PREAMBLE_SYMS(P), .PREAMBLE_WORD(4'b1001),
        .SYNC_WORD(16'hF3A0), .GUARD_SYMS(G)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fb(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [3:0]  pw = 4'b1001;
    logic [15:0] sw = 16'hF3A0;

    // model state
    logic        m_active = 1'b0;
    int          m_r = 0;
    int          m_L = 0;
    int          m_N = 0;
    logic [7:0]  m_buf = 8'h00;
    logic        m_full = 1'b0;
    int          m_acc = 0;
    logic        m_underrun = 1'b0;
    logic        m_done = 1'b0;
    logic [7:0]  m_bytes [256];

    // stimulus and observation state
    int          cyc = 0;
    int          t_acc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          strobe_cnt = 0;
    int          dut_hs = 0;
    int          be_last = 0;
    logic        be_prev = 1'b0;
    logic        done_flag = 1'b0;
    logic [127:0] cap = '0;
    logic [6:0]  last_obs = '0;
    int          vmode = 0;
    int          v_gap = 0;
    logic [7:0]  cur_data = 8'h00;
    logic [7:0]  src_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] next_data();
        if (src_q.size() > 0) return src_q.pop_front();
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic m_bit(input int k);
        if (k < 4 * P) return pw[3 - (k % 4)];
        if (k < PB) return sw[15 - (k - 4 * P)];
        if (k < PB + 8 * m_L) return m_bytes[(k - PB) / 8][7 - ((k - PB) % 8)];
        return 1'b0;
    endfunction

    function automatic logic m_inrdy();
        int k;
        if (!m_active) return 1'b0;
        k = (m_r - 1) / D;
        return (k >= 4 * P) && (k < PB + 8 * m_L) && !m_full && (m_acc < m_L);
    endfunction

    // expected {signal, bit_en, sym_strobe, busy, done, underrun, in_ready}
    function automatic logic [6:0] m_exp();
        int k;
        logic be;
        if (!m_active) return {4'b0000, m_done, m_underrun, 1'b0};
        k = (m_r - 1) / D;
        be = (((m_r - 1) % D) == D - 1);
        return {m_bit(k), be, be && ((k % 4) == 3), 1'b1, m_done, m_underrun, m_inrdy()};
    endfunction

    task automatic m_reset();
        m_active = 1'b0; m_full = 1'b0; m_underrun = 1'b0; m_done = 1'b0;
        m_acc = 0; m_r = 0;
    endtask

    // advance the model across one rising edge with the given inputs
    task automatic m_adv(input logic st, input logic ab, input logic [7:0] len,
                         input logic v, input logic [7:0] d, output logic hs);
        int k;
        int j;
        logic be;
        hs = 1'b0;
        m_done = 1'b0;
        if (ab) begin
            m_active = 1'b0;
            m_full = 1'b0;
        end else if (!m_active) begin
            if (st && (len != 8'd0)) begin
                m_active = 1'b1; m_r = 1; m_L = int'(len);
                m_N = PB + 8 * m_L + 4 * G;
                m_full = 1'b0; m_acc = 0; m_underrun = 1'b0;
                t_acc = cyc;
            end
        end else begin
            k = (m_r - 1) / D;
            be = (((m_r - 1) % D) == D - 1);
            hs = v && m_inrdy();
            if (be && (k + 1 >= PB) && (k + 1 < PB + 8 * m_L) && (((k + 1 - PB) % 8) == 0)) begin
                j = (k + 1 - PB) / 8;
                m_bytes[j] = m_full ? m_buf : 8'h00;
                if (!m_full) m_underrun = 1'b1;
                m_full = 1'b0;
            end
            if (hs) begin
                m_buf = d; m_full = 1'b1; m_acc++;
            end
            if (be && (k == m_N - 1)) begin
                m_active = 1'b0;
                m_done = 1'b1;
            end else begin
                m_r++;
            end
        end
    endtask

    // one clock: compare outputs at negedge, drive inputs, advance model
    task automatic step(input logic st, input logic ab, input logic [7:0] len);
        logic [6:0] act;
        logic v;
        logic hs;
        @(negedge clk);
        act = {bus.signal, bus.bit_en, bus.sym_strobe, bus.busy, bus.done, bus.underrun, bus.in_ready};
        last_obs = act;
        chk("cycle outputs {sig,be,sym,busy,done,unr,rdy}", 128'(act), 128'(m_exp()));
        if (bus.bit_en) begin
            cap = {cap[126:0], bus.signal};
            if (bus.sym_strobe) strobe_cnt++;
            if (be_prev) chk("bit_en period", 128'(cyc - be_last), 128'(D));
            be_last = cyc;
            be_prev = 1'b1;
        end
        if (!bus.busy) be_prev = 1'b0;
        if (bus.done) begin
            done_cnt++; done_cyc = cyc; done_flag = 1'b1;
        end
        case (vmode)
            0: v = 1'b1;
            1: v = m_active && (m_r > (PB + 8) * D);
            default: begin
                v = (v_gap >= 20) ? 1'b1 : ($urandom_range(0, 2) != 0);
                v_gap = v ? 0 : v_gap + 1;
            end
        endcase
        bus.start = st;
        bus.abort = ab;
        bus.frame_len = len;
        bus.in_valid = v;
        bus.in_data = cur_data;
        if (bus.in_valid && bus.in_ready) dut_hs++;
        m_adv(st, ab, len, v, cur_data, hs);
        if (hs) cur_data = next_data();
        cyc++;
    endtask

    task automatic run_frame(input int limit);
        done_flag = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step(1'b0, 1'b0, 8'd0);
            if (done_flag) break;
        end
        if (!done_flag) chk("frame completion timeout", 128'd0, 128'd1);
    endtask

    task automatic load_src(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] e, input int n);
        logic [7:0] lst [4];
        lst[0] = a; lst[1] = b; lst[2] = c; lst[3] = e;
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(lst[i]);
        cur_data = next_data();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.frame_len = 8'd0;
        bus.in_valid = 1'b0; bus.in_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset outputs", 128'({bus.signal, bus.bit_en, bus.sym_strobe, bus.busy,
                                   bus.done, bus.underrun, bus.in_ready}), 128'd0);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 8'd0);

        // 1: basic frame, two bytes always valid
        vmode = 0;
        load_src(8'hA5, 8'h3C, 8'h00, 8'h00, 2);
        strobe_cnt = 0;
        step(1'b1, 1'b0, 8'd2);
        run_frame(2000);
        chk("t1 done latency", 128'(done_cyc - t_acc), 128'd577);
        chk("t1 strobes", 128'(strobe_cnt), 128'd18);
        chk("t1 bitstream", 128'(cap[71:0]), 128'(72'h99999999_F3A0_A53C_00));
        chk("t1 underrun", 128'(last_obs[1]), 128'd0);
        repeat (4) step(1'b0, 1'b0, 8'd0);

        // 2: late payload -> zero bytes and underrun, cleared by next start
        vmode = 1;
        load_src(8'h11, 8'h22, 8'h33, 8'h44, 4);
        step(1'b1, 1'b0, 8'd4);
        run_frame(2000);
        chk("t2 payload", 128'(cap[39:8]), 128'h00001122);
        chk("t2 length", 128'(done_cyc - t_acc), 128'(1 + (PB + 32 + 4 * G) * D));
        step(1'b0, 1'b0, 8'd0);
        chk("t2 underrun sticky", 128'(last_obs[1]), 128'd1);
        vmode = 0;
        load_src(8'h55, 8'h00, 8'h00, 8'h00, 1);
        step(1'b1, 1'b0, 8'd1);
        step(1'b0, 1'b0, 8'd0);
        chk("t2 underrun cleared", 128'(last_obs[1]), 128'd0);
        run_frame(2000);
        chk("t2 recovery payload", 128'(cap[15:8]), 128'h55);

        // 3: abort in sync section
        done_cnt = 0;
        load_src(8'h12, 8'h34, 8'h56, 8'h00, 3);
        step(1'b1, 1'b0, 8'd3);
        for (int i = 0; i < 2000 && m_r < 300; i++) step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("t3 abort sig/busy/done", 128'({last_obs[6], last_obs[3], last_obs[2]}), 128'd0);
        repeat (20) step(1'b0, 1'b0, 8'd0);
        chk("t3 no done", 128'(done_cnt), 128'd0);

        // 4: ignored starts
        step(1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("t4 len0 busy/done", 128'({last_obs[3], last_obs[2]}), 128'd0);
        step(1'b1, 1'b1, 8'd5);
        step(1'b0, 1'b0, 8'd0);
        chk("t4 abort beats start", 128'(last_obs[3]), 128'd0);
        load_src(8'h77, 8'h00, 8'h00, 8'h00, 1);
        step(1'b1, 1'b0, 8'd1);
        repeat (10) step(1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd5);
        run_frame(2000);
        chk("t4 len unchanged", 128'(done_cyc - t_acc), 128'd513);
        chk("t4 done count", 128'(done_cnt), 128'd1);

        // 5: reset in payload, then a full frame
        load_src(8'h01, 8'h02, 8'h03, 8'h00, 3);
        step(1'b1, 1'b0, 8'd3);
        for (int i = 0; i < 2000 && m_r < PB * D + 20; i++) step(1'b0, 1'b0, 8'd0);
        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("t5 reset outputs", 128'({bus.signal, bus.bit_en, bus.sym_strobe, bus.busy,
                                      bus.done, bus.underrun, bus.in_ready}), 128'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        load_src(8'h5A, 8'hC3, 8'h00, 8'h00, 2);
        step(1'b1, 1'b0, 8'd2);
        run_frame(2000);
        chk("t5 bitstream", 128'(cap[71:0]), 128'(72'h99999999_F3A0_5AC3_00));
        chk("t5 done latency", 128'(done_cyc - t_acc), 128'd577);

        // 6: long frame with random valid gaps
        vmode = 2;
        v_gap = 0;
        src_q.delete();
        cur_data = next_data();
        dut_hs = 0;
        step(1'b1, 1'b0, 8'd255);
        run_frame(20000);
        chk("t6 handshakes", 128'(dut_hs), 128'd255);
        chk("t6 no underrun", 128'(last_obs[1]), 128'd0);
        chk("t6 done latency", 128'(done_cyc - t_acc), 128'(1 + (PB + 8 * 255 + 4 * G) * D));
        repeat (3) step(1'b0, 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
